// File: rtl/spi_tx_sequencer_pkg.sv
// Shared definitions for the SPI transmit sequencer: FSM state encoding,
// header field layout, default fill byte / header magic, and small helpers
// for header construction, checksum update and round-robin indexing.
package spi_tx_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;
  localparam logic [3:0] HDR_MAGIC_DEFAULT = 4'hA;

  // Header layout: [7:4] magic, [3] reserved zero, [2:0] source index.
  localparam int HDR_MAGIC_LSB = 4;
  localparam int HDR_RSVD_BIT  = 3;
  localparam int HDR_IDX_LSB   = 0;

  function automatic logic [7:0] make_header(input logic [3:0] magic,
                                             input logic [2:0] idx);
    logic [7:0] hdr;
    hdr                        = 8'h00;
    hdr[HDR_MAGIC_LSB +: 4]    = magic;
    hdr[HDR_RSVD_BIT]          = 1'b0;
    hdr[HDR_IDX_LSB +: 3]      = idx;
    return hdr;
  endfunction

  // 8-bit XOR checksum, no carry.
  function automatic logic [7:0] csum_update(input logic [7:0] csum,
                                             input logic [7:0] data);
    return csum ^ data;
  endfunction

  // Source index visited at step 'offset' when searching upward from 'base'.
  function automatic logic [2:0] rr_index(input logic [2:0] base,
                                          input int offset,
                                          input int n);
    return 3'((int'(base) + offset) % n);
  endfunction

endpackage

// File: rtl/spi_tx_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter. Searches the request vector upward
// starting at the pointer (wrapping at NREQ) and reports the first requester.
// Ports:
//   req   in  NREQ  request vector
//   ptr   in  3     search start index (< NREQ)
//   grant out NREQ  one-hot grant (all zero when no request)
//   idx   out 3     index of the granted requester (0 when none)
//   any   out 1     at least one request present
module spi_tx_sequencer_rr_arbiter
  import spi_tx_sequencer_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      idx,
  output logic            any
);

  logic hit_s;

  // Priority search from the pointer; the first hit locks out later ones.
  always_comb begin
    grant = '0;
    idx   = 3'd0;
    any   = 1'b0;
    hit_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        hit_s    = !any && (3'(j) == rr_index(ptr, i, NREQ)) && req[j];
        grant[j] = grant[j] | hit_s;
        idx      = hit_s ? 3'(j) : idx;
        any      = any | hit_s;
      end
    end
  end

endmodule

// File: rtl/spi_tx_sequencer.sv
// Outgoing traffic sequencer for the SPI slave core. At every byte slot it
// loads one byte into the core: a header, payload from the round-robin
// granted source, an XOR checksum, or the fill byte when nothing is pending.
// Packets cut short by frame end are drained from the source and counted.
// Ports:
//   i_clk, i_rst_l         clock, async active-low reset
//   i_frame_active         chip select asserted (synchronised)
//   i_byte_done            SPI core finished the current byte slot
//   i_src_valid/data/last  per-source payload offer (source k: data[8k+7:8k])
//   o_src_ready            per-source consume pulse
//   o_tx_dv, o_tx_byte     load strobe and byte to the SPI core
//   o_busy                 packet in progress
//   o_grant                current/last granted source index
//   o_underrun             payload slot filled with the fill byte
//   o_abort_cnt            saturating count of aborted packets
module spi_tx_sequencer
  import spi_tx_sequencer_pkg::*;
#(
  parameter int         NREQ      = 2,
  parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEFAULT,
  parameter logic [3:0] HDR_MAGIC = HDR_MAGIC_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst_l,
  input  logic              i_frame_active,
  input  logic              i_byte_done,
  input  logic [NREQ-1:0]   i_src_valid,
  input  logic [8*NREQ-1:0] i_src_data,
  input  logic [NREQ-1:0]   i_src_last,
  output logic [NREQ-1:0]   o_src_ready,
  output logic              o_tx_dv,
  output logic [7:0]        o_tx_byte,
  output logic              o_busy,
  output logic [2:0]        o_grant,
  output logic              o_underrun,
  output logic [7:0]        o_abort_cnt
);

  localparam logic [2:0] LAST_IDX = 3'(NREQ - 1);

  state_t          state_r, state_s;
  logic [2:0]      ptr_r, ptr_s;
  logic [2:0]      grant_r, grant_s;
  logic [NREQ-1:0] grant_oh_r, grant_oh_s;
  logic [7:0]      csum_r, csum_s;
  logic [7:0]      abort_r, abort_s;
  logic            frame_d_r;
  logic            tx_dv_r, tx_dv_s;
  logic [7:0]      tx_byte_r, tx_byte_s;
  logic [NREQ-1:0] src_ready_r, src_ready_s;
  logic            busy_r, busy_s;
  logic            underrun_r, underrun_s;

  logic [NREQ-1:0] arb_grant_s;
  logic [2:0]      arb_idx_s;
  logic            arb_any_s;
  logic            load_s;
  logic            sel_valid_s, sel_last_s, sel_pending_s;
  logic [7:0]      sel_data_s;
  logic [2:0]      next_ptr_s;
  logic [7:0]      hdr_s;

  spi_tx_sequencer_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (i_src_valid),
    .ptr   (ptr_r),
    .grant (arb_grant_s),
    .idx   (arb_idx_s),
    .any   (arb_any_s)
  );

  // Offer of the granted source and derived per-slot quantities.
  always_comb begin
    load_s        = i_frame_active && (!frame_d_r || i_byte_done);
    sel_valid_s   = |(i_src_valid & grant_oh_r);
    sel_last_s    = |(i_src_last & grant_oh_r);
    // A ready pulse still in flight means the source has not yet advanced.
    sel_pending_s = |(src_ready_r & grant_oh_r);
    sel_data_s    = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      sel_data_s = sel_data_s | ({8{grant_oh_r[k]}} & i_src_data[8*k +: 8]);
    end
    next_ptr_s = (grant_r == LAST_IDX) ? 3'd0 : grant_r + 3'd1;
    hdr_s      = make_header(HDR_MAGIC, arb_idx_s);
  end

  // Next-state and registered-output logic for the sequencer FSM.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    grant_s     = grant_r;
    grant_oh_s  = grant_oh_r;
    csum_s      = csum_r;
    abort_s     = abort_r;
    tx_dv_s     = 1'b0;
    tx_byte_s   = tx_byte_r;
    src_ready_s = '0;
    busy_s      = busy_r;
    underrun_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_SELECT: begin
        if (!i_frame_active) begin
          state_s = ST_IDLE;
        end else if (load_s) begin
          tx_dv_s = 1'b1;
          if (arb_any_s) begin
            tx_byte_s  = hdr_s;
            csum_s     = hdr_s;
            grant_s    = arb_idx_s;
            grant_oh_s = arb_grant_s;
            busy_s     = 1'b1;
            state_s    = ST_PAYLOAD;
          end else begin
            tx_byte_s = FILL_BYTE;
            state_s   = ST_SELECT;
          end
        end else begin
          state_s = ST_SELECT;
        end
      end
      ST_PAYLOAD: begin
        if (!i_frame_active) begin
          abort_s = (abort_r == 8'hFF) ? abort_r : abort_r + 8'd1;
          state_s = ST_DRAIN;
        end else if (load_s) begin
          tx_dv_s = 1'b1;
          if (sel_valid_s) begin
            tx_byte_s   = sel_data_s;
            src_ready_s = grant_oh_r;
            csum_s      = csum_update(csum_r, sel_data_s);
            state_s     = sel_last_s ? ST_CSUM : ST_PAYLOAD;
          end else begin
            tx_byte_s  = FILL_BYTE;
            underrun_s = 1'b1;
          end
        end else begin
          state_s = ST_PAYLOAD;
        end
      end
      ST_CSUM: begin
        if (!i_frame_active) begin
          busy_s  = 1'b0;
          ptr_s   = next_ptr_s;
          state_s = ST_IDLE;
        end else if (load_s) begin
          tx_dv_s   = 1'b1;
          tx_byte_s = csum_r;
          busy_s    = 1'b0;
          ptr_s     = next_ptr_s;
          state_s   = ST_SELECT;
        end else begin
          state_s = ST_CSUM;
        end
      end
      ST_DRAIN: begin
        // A reopened frame gets fill bytes until the aborted packet is gone.
        if (load_s) begin
          tx_dv_s   = 1'b1;
          tx_byte_s = FILL_BYTE;
        end else begin
          tx_dv_s = 1'b0;
        end
        if (sel_valid_s && !sel_pending_s) begin
          src_ready_s = grant_oh_r;
          if (sel_last_s) begin
            busy_s  = 1'b0;
            ptr_s   = next_ptr_s;
            state_s = i_frame_active ? ST_SELECT : ST_IDLE;
          end else begin
            state_s = ST_DRAIN;
          end
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      state_r     <= ST_IDLE;
      ptr_r       <= 3'd0;
      grant_r     <= 3'd0;
      grant_oh_r  <= NREQ'(1);
      csum_r      <= 8'h00;
      abort_r     <= 8'h00;
      frame_d_r   <= 1'b0;
      tx_dv_r     <= 1'b0;
      tx_byte_r   <= FILL_BYTE;
      src_ready_r <= '0;
      busy_r      <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      grant_r     <= grant_s;
      grant_oh_r  <= grant_oh_s;
      csum_r      <= csum_s;
      abort_r     <= abort_s;
      frame_d_r   <= i_frame_active;
      tx_dv_r     <= tx_dv_s;
      tx_byte_r   <= tx_byte_s;
      src_ready_r <= src_ready_s;
      busy_r      <= busy_s;
      underrun_r  <= underrun_s;
    end
  end

  assign o_src_ready = src_ready_r;
  assign o_tx_dv     = tx_dv_r;
  assign o_tx_byte   = tx_byte_r;
  assign o_busy      = busy_r;
  assign o_grant     = grant_r;
  assign o_underrun  = underrun_r;
  assign o_abort_cnt = abort_r;

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Self-checking bench for spi_tx_sequencer (NREQ=2). Table-driven framing
// tests plus hand-written abort, underrun and reset sequences.
module tb_spi_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame;
  logic        done;
  logic [1:0]  src_valid;
  logic [15:0] src_data;
  logic [1:0]  src_last;
  logic [1:0]  hold;
  logic [1:0]  src_ready;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        busy;
  logic [2:0]  grant;
  logic        underrun;
  logic [7:0]  abort_cnt;

  logic [8:0]  srcq [2][$];
  logic [7:0]  cap [$];
  logic [7:0]  exp_q [$];
  int          rdy_cnt [2];
  int          und_cnt;
  logic        busy_seen;
  int          checks = 0;
  int          errors = 0;

  typedef struct { int tid; int src; logic [7:0] data; logic last; } stim_t;
  typedef struct { int tid; logic [7:0] exp; } exp_t;
  stim_t stim [5];
  exp_t  expv [17];

  spi_tx_sequencer #(.NREQ(2)) dut (
    .i_clk          (clk),
    .i_rst_l        (rst_n),
    .i_frame_active (frame),
    .i_byte_done    (done),
    .i_src_valid    (src_valid),
    .i_src_data     (src_data),
    .i_src_last     (src_last),
    .o_src_ready    (src_ready),
    .o_tx_dv        (tx_dv),
    .o_tx_byte      (tx_byte),
    .o_busy         (busy),
    .o_grant        (grant),
    .o_underrun     (underrun),
    .o_abort_cnt    (abort_cnt)
  );

  always #5 clk = ~clk;

  // Monitor and source model, evaluated on the falling edge.
  initial begin
    src_valid = 2'b00;
    src_data  = 16'h0000;
    src_last  = 2'b00;
    forever begin
      @(negedge clk);
      if (tx_dv) cap.push_back(tx_byte);
      if (underrun) und_cnt++;
      if (busy) busy_seen = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (src_ready[k]) begin
          rdy_cnt[k]++;
          if (srcq[k].size() > 0) void'(srcq[k].pop_front());
        end
        src_valid[k]        = (srcq[k].size() > 0) && !hold[k];
        src_data[8*k +: 8]  = (srcq[k].size() > 0) ? srcq[k][0][7:0] : 8'h00;
        src_last[k]         = (srcq[k].size() > 0) ? srcq[k][0][8] : 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cap(input string name);
    check({name, "_count"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      check($sformatf("%s[%0d]", name, i), {24'h0, cap[i]}, {24'h0, exp_q[i]});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    wait_cycles(3);
    done = 1'b1;
    wait_cycles(1);
    done = 1'b0;
  endtask

  task automatic clear_tb();
    frame = 1'b0;
    done  = 1'b0;
    hold  = 2'b00;
    srcq[0].delete();
    srcq[1].delete();
    cap.delete();
    rdy_cnt[0] = 0;
    rdy_cnt[1] = 0;
    und_cnt    = 0;
    busy_seen  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_tb();
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(1);
  endtask

  task automatic push(input int src, input logic [7:0] d, input logic last);
    srcq[src].push_back({last, d});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_dv"},    tx_dv,     1'b0);
    check({tag, "_tx_byte"},  tx_byte,   8'hFF);
    check({tag, "_ready"},    src_ready, 2'b00);
    check({tag, "_busy"},     busy,      1'b0);
    check({tag, "_grant"},    grant,     3'd0);
    check({tag, "_underrun"}, underrun,  1'b0);
    check({tag, "_abort"},    abort_cnt, 8'h00);
  endtask

  initial begin
    stim[0] = '{1, 0, 8'h11, 1'b0};
    stim[1] = '{1, 0, 8'h22, 1'b0};
    stim[2] = '{1, 0, 8'h33, 1'b1};
    stim[3] = '{2, 0, 8'h5A, 1'b1};
    stim[4] = '{2, 1, 8'hC3, 1'b1};
    expv[0]  = '{1, 8'hA0}; expv[1]  = '{1, 8'h11}; expv[2]  = '{1, 8'h22};
    expv[3]  = '{1, 8'h33}; expv[4]  = '{1, 8'hA0}; expv[5]  = '{1, 8'hFF};
    expv[6]  = '{2, 8'hA0}; expv[7]  = '{2, 8'h5A}; expv[8]  = '{2, 8'hFA};
    expv[9]  = '{2, 8'hA1}; expv[10] = '{2, 8'hC3}; expv[11] = '{2, 8'h62};
    expv[12] = '{2, 8'hFF};
    expv[13] = '{3, 8'hFF}; expv[14] = '{3, 8'hFF}; expv[15] = '{3, 8'hFF};
    expv[16] = '{3, 8'hFF};

    do_reset();
    check_reset_outputs("reset");

    // Table-driven framing tests.
    for (int t = 1; t <= 3; t++) begin
      do_reset();
      foreach (stim[i]) if (stim[i].tid == t) push(stim[i].src, stim[i].data, stim[i].last);
      exp_q.delete();
      foreach (expv[i]) if (expv[i].tid == t) exp_q.push_back(expv[i].exp);
      wait_cycles(2);
      cap.delete();
      busy_seen = 1'b0;
      frame = 1'b1;
      for (int s = 1; s < exp_q.size(); s++) pulse_done();
      wait_cycles(3);
      frame = 1'b0;
      wait_cycles(5);
      check_cap($sformatf("t%0d_bytes", t));
      case (t)
        1: check("t1_ready0", rdy_cnt[0], 3);
        2: begin
          check("t2_ready0", rdy_cnt[0], 1);
          check("t2_ready1", rdy_cnt[1], 1);
          check("t2_ptr", dut.ptr_r, 3'd0);
        end
        3: check("t3_busy_seen", busy_seen, 1'b0);
        default: check("t_unknown", t, 0);
      endcase
    end

    // Abort after two of four payload bytes, then a fresh packet.
    do_reset();
    push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b0); push(0, 8'h04, 1'b1);
    wait_cycles(2);
    frame = 1'b1;
    pulse_done();
    pulse_done();
    wait_cycles(3);
    frame = 1'b0;
    wait_cycles(20);
    exp_q = '{8'hA0, 8'h01, 8'h02};
    check_cap("t4_bytes");
    check("t4_abort", abort_cnt, 8'd1);
    check("t4_ready0", rdy_cnt[0], 4);
    check("t4_queue_left", srcq[0].size(), 0);
    check("t4_busy", busy, 1'b0);
    push(0, 8'h77, 1'b1);
    wait_cycles(2);
    cap.delete();
    frame = 1'b1;
    pulse_done();
    pulse_done();
    wait_cycles(3);
    frame = 1'b0;
    wait_cycles(5);
    exp_q = '{8'hA0, 8'h77, 8'hD7};
    check_cap("t4_next");
    check("t4_abort_hold", abort_cnt, 8'd1);

    // Underrun: source 1 drops valid for one slot mid-packet.
    do_reset();
    push(1, 8'h10, 1'b0); push(1, 8'h20, 1'b0); push(1, 8'h30, 1'b1);
    wait_cycles(2);
    frame = 1'b1;
    pulse_done();
    hold[1] = 1'b1;
    pulse_done();
    hold[1] = 1'b0;
    pulse_done();
    pulse_done();
    pulse_done();
    pulse_done();
    wait_cycles(3);
    frame = 1'b0;
    wait_cycles(5);
    exp_q = '{8'hA1, 8'h10, 8'hFF, 8'h20, 8'h30, 8'hA1, 8'hFF};
    check_cap("t5_bytes");
    check("t5_underrun", und_cnt, 1);
    check("t5_ready1", rdy_cnt[1], 3);

    // Reset mid-payload with the pointer advanced past source 0.
    do_reset();
    push(0, 8'h01, 1'b1);
    push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b0); push(1, 8'hB2, 1'b1);
    wait_cycles(2);
    frame = 1'b1;
    repeat (4) pulse_done();
    wait_cycles(2);
    exp_q = '{8'hA0, 8'h01, 8'hA1, 8'hA1, 8'hB0};
    check_cap("t6_pre");
    check("t6_pre_busy", busy, 1'b1);
    check("t6_pre_grant", grant, 3'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    clear_tb();
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(1);
    push(0, 8'h5A, 1'b1);
    push(1, 8'hC3, 1'b1);
    wait_cycles(2);
    frame = 1'b1;
    pulse_done();
    wait_cycles(3);
    frame = 1'b0;
    wait_cycles(5);
    exp_q = '{8'hA0, 8'h5A};
    check_cap("t6_post");
    check("t6_post_grant", grant, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
